// File: rtl/cyc_account_unit_pkg.sv
// Shared types and CSR addresses for the cycle-accounting counter bank.
// Holds the core configuration, CSR map, STATUS layout and address decode.
package cyc_account_unit_pkg;

   typedef struct packed {
      logic [31:0] XLEN;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd64};

   localparam logic [11:0] CSR_CNT_DATA   = 12'h8C0;
   localparam logic [11:0] CSR_CNT_DATA_H = 12'h8C1;
   localparam logic [11:0] CSR_CNT_STATUS = 12'h8C2;
   localparam logic [11:0] CSR_CNT_OVF    = 12'h8C3;

   localparam int unsigned IdxWidth = 8;

   typedef struct packed {
      logic                count_en;
      logic [IdxWidth-1:0] sel_idx;
      logic [IdxWidth-1:0] active_idx;
   } cyc_acc_status_t;

   localparam int unsigned StatusWidth = $bits(cyc_acc_status_t);

   typedef enum logic [2:0] {
      CSR_SEL_NONE,
      CSR_SEL_DATA,
      CSR_SEL_DATA_H,
      CSR_SEL_STATUS,
      CSR_SEL_OVF
   } csr_sel_e;

   function automatic csr_sel_e decode_csr(input logic [11:0] addr);
      csr_sel_e sel;
      sel = CSR_SEL_NONE;
      case (addr)
         CSR_CNT_DATA:   sel = CSR_SEL_DATA;
         CSR_CNT_DATA_H: sel = CSR_SEL_DATA_H;
         CSR_CNT_STATUS: sel = CSR_SEL_STATUS;
         CSR_CNT_OVF:    sel = CSR_SEL_OVF;
         default:        sel = CSR_SEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/cyc_account_unit_slice.sv
// One counter register of the bank: increment, split low/high write ports,
// and a wrap strobe that fires in the cycle the counter rolls over to zero.
module cyc_counter_slice
#(
   parameter int unsigned CounterWidth = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    inc_i,
   input  logic                    wr_lo_i,
   input  logic                    wr_hi_i,
   input  logic [31:0]             wr_lo_data_i,
   input  logic [31:0]             wr_hi_data_i,
   output logic [CounterWidth-1:0] cnt_o,
   output logic                    wrap_o
);

   logic [CounterWidth-1:0] cnt_q, cnt_d;
   logic [63:0]             wr_val;

   // A software write always replaces the increment of the same cycle.
   always_comb begin
      wr_val = 64'(cnt_q);
      if (wr_lo_i) wr_val[31:0] = wr_lo_data_i;
      if (wr_hi_i) wr_val[63:32] = wr_hi_data_i;
      cnt_d  = cnt_q;
      wrap_o = 1'b0;
      if (wr_lo_i || wr_hi_i) begin
         cnt_d = wr_val[CounterWidth-1:0];
      end else if (inc_i) begin
         cnt_d  = cnt_q + CounterWidth'(1);
         wrap_o = &cnt_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/cyc_account_unit.sv
// Cycle-accounting counter bank: one active counter counts non-debug cycles,
// software reaches every counter through a select window in CSR space.
module cyc_account_unit
   import cyc_account_unit_pkg::*;
#(
   parameter cva6_cfg_t   CVA6Cfg      = cva6_cfg_empty,
   parameter int unsigned NrCounters   = 8,
   parameter int unsigned CounterWidth = 64
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      debug_mode_i,
   input  logic [11:0]               addr_i,
   input  logic                      we_i,
   input  logic                      re_i,
   input  logic [CVA6Cfg.XLEN-1:0]   data_i,
   output logic [CVA6Cfg.XLEN-1:0]   data_o,
   output logic                      access_ex_o,
   input  logic                      ctx_switch_i,
   input  logic [IdxWidth-1:0]       ctx_idx_i,
   output logic                      ovf_o
);

   localparam int unsigned XLEN = CVA6Cfg.XLEN;

   cyc_acc_status_t         status_q, status_d;
   logic [NrCounters-1:0]   ovf_q, ovf_d, ovf_clr;
   logic [NrCounters-1:0]   inc, wr_lo, wr_hi, wrap;
   logic [CounterWidth-1:0] cnt [NrCounters];
   csr_sel_e                csr_sel;
   logic                    status_wr_ok, illegal, legal_wr;
   logic [63:0]             wdata64, sel_cnt64;
   logic [31:0]             hi_wdata;
   logic [255:0]            ovf_ext;

   assign csr_sel = decode_csr(addr_i);
   assign status_wr_ok = ({1'b0, data_i[7:0]} < 9'(NrCounters)) &&
                         ({1'b0, data_i[15:8]} < 9'(NrCounters));

   // A rejected access must leave all software-visible state untouched.
   always_comb begin
      illegal = 1'b0;
      if (re_i || we_i) begin
         case (csr_sel)
            CSR_SEL_NONE:   illegal = 1'b1;
            CSR_SEL_DATA_H: illegal = (XLEN != 32);
            CSR_SEL_STATUS: illegal = we_i && !status_wr_ok;
            default:        illegal = 1'b0;
         endcase
      end
   end

   assign access_ex_o = illegal;
   assign legal_wr    = we_i && !illegal;
   assign wdata64     = 64'(data_i);
   assign hi_wdata    = (XLEN == 64) ? wdata64[63:32] : wdata64[31:0];

   always_comb begin
      sel_cnt64 = '0;
      for (int i = 0; i < NrCounters; i++) begin
         if (status_q.sel_idx == IdxWidth'(i)) sel_cnt64 = 64'(cnt[i]);
      end
   end

   assign ovf_ext = 256'(ovf_q);

   always_comb begin
      data_o = '0;
      if (re_i && !illegal) begin
         case (csr_sel)
            CSR_SEL_DATA:   data_o = sel_cnt64[XLEN-1:0];
            CSR_SEL_DATA_H: data_o = XLEN'(sel_cnt64[63:32]);
            CSR_SEL_STATUS: data_o = XLEN'(status_q);
            CSR_SEL_OVF:    data_o = ovf_ext[XLEN-1:0];
            default:        data_o = '0;
         endcase
      end
   end

   // A software STATUS write overrides a same-cycle hardware context switch.
   always_comb begin
      status_d = status_q;
      if (ctx_switch_i && ({1'b0, ctx_idx_i} < 9'(NrCounters))) begin
         status_d.active_idx = ctx_idx_i;
      end
      if (legal_wr && (csr_sel == CSR_SEL_STATUS)) begin
         status_d = cyc_acc_status_t'(data_i[StatusWidth-1:0]);
      end
   end

   for (genvar g = 0; g < NrCounters; g++) begin : gen_cnt
      logic hit;
      assign hit      = legal_wr && (status_q.sel_idx == IdxWidth'(g));
      assign inc[g]   = status_q.count_en && !debug_mode_i &&
                        (status_q.active_idx == IdxWidth'(g));
      assign wr_lo[g] = hit && (csr_sel == CSR_SEL_DATA);
      assign wr_hi[g] = hit && (((XLEN == 64) && (csr_sel == CSR_SEL_DATA)) ||
                                ((XLEN == 32) && (csr_sel == CSR_SEL_DATA_H)));

      cyc_counter_slice #(
         .CounterWidth (CounterWidth)
      ) u_slice (
         .clk_i        (clk_i),
         .rst_ni       (rst_ni),
         .inc_i        (inc[g]),
         .wr_lo_i      (wr_lo[g]),
         .wr_hi_i      (wr_hi[g]),
         .wr_lo_data_i (wdata64[31:0]),
         .wr_hi_data_i (hi_wdata),
         .cnt_o        (cnt[g]),
         .wrap_o       (wrap[g])
      );
   end

   // Wrap is OR'ed in after the clear so a simultaneous wrap keeps the flag.
   assign ovf_clr = (legal_wr && (csr_sel == CSR_SEL_OVF)) ? NrCounters'(data_i) : '0;
   assign ovf_d   = (ovf_q & ~ovf_clr) | wrap;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         status_q <= '0;
         ovf_q    <= '0;
      end else begin
         status_q <= status_d;
         ovf_q    <= ovf_d;
      end
   end

   assign ovf_o = |ovf_q;

endmodule
